// File: rtl/midi_note_tracker_if.sv
// MIDI note tracker bus: receiver byte strobe in, note events and held-key
// status out.
//
// Strobe semantics: MIDI_BYTE is valid while MIDI_RDY is high. The tracker
// has no back-pressure (it is always ready) and consumes exactly one byte per
// rising edge of MIDI_RDY, no matter how long the strobe stays high.
// EVT_VALID/ERR are one-cycle pulses; EVT_ON/EVT_KEY/EVT_VEL hold until the
// next event. GATE/CUR_KEY/CUR_VEL/HELD_CNT are continuous status.
interface midi_note_tracker_if;
  logic       MIDI_RDY;
  logic [7:0] MIDI_BYTE;
  logic       EVT_VALID;
  logic       EVT_ON;
  logic [6:0] EVT_KEY;
  logic [6:0] EVT_VEL;
  logic       GATE;
  logic [6:0] CUR_KEY;
  logic [6:0] CUR_VEL;
  logic [2:0] HELD_CNT;
  logic       ERR;

  modport master (
    output MIDI_RDY, MIDI_BYTE,
    input  EVT_VALID, EVT_ON, EVT_KEY, EVT_VEL, GATE, CUR_KEY, CUR_VEL,
           HELD_CNT, ERR
  );

  modport slave (
    input  MIDI_RDY, MIDI_BYTE,
    output EVT_VALID, EVT_ON, EVT_KEY, EVT_VEL, GATE, CUR_KEY, CUR_VEL,
           HELD_CNT, ERR
  );
endinterface

// File: rtl/midi_note_tracker.sv
// MIDI channel-voice parser with running status, realtime/system filtering,
// channel selection and a 4-deep last-note-priority stack of held keys.
module midi_note_tracker #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic                      clk500kHz,
  input  logic                      RESET,
  midi_note_tracker_if.slave        bus,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_D1   = 2'd1,
    ST_D2   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_q;
  logic       accept;
  logic [7:0] byte_in;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  logic       msg_done;
  logic [6:0] msg_d1, msg_d2;
  logic       err_d;
  logic       match;
  logic       note_on, note_off, all_off;

  logic [6:0] key_q [4];
  logic [6:0] vel_q [4];
  logic [2:0] depth_q;
  logic [6:0] key_d [4];
  logic [6:0] vel_d [4];
  logic [2:0] depth_d;

  logic [6:0] ext_key [5];
  logic [6:0] ext_vel [5];
  logic [6:0] rem_key [4];
  logic [6:0] rem_vel [4];
  logic [2:0] rem_depth;
  logic       found;
  logic [1:0] idx;

  logic       evt_valid_q, evt_on_q, err_q;
  logic [6:0] evt_key_q, evt_vel_q;

  assign byte_in   = bus.MIDI_BYTE;
  assign accept    = bus.MIDI_RDY & ~rdy_q;
  assign dbg_state = state_q;

  // Strobe edge detector; resets high so a strobe already high at reset release is ignored.
  always_ff @(posedge clk500kHz or posedge RESET) begin
    if (RESET) rdy_q <= 1'b1;
    else       rdy_q <= bus.MIDI_RDY;
  end

  // Parser state, running status and first data byte.
  always_ff @(posedge clk500kHz or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      status_q <= 8'd0;
      d1_q     <= 7'd0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Byte classification, next parser state and message completion decode.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_d1   = 7'd0;
    msg_d2   = 7'd0;
    err_d    = 1'b0;
    if (accept) begin
      if (byte_in >= 8'hF8) begin
        // Realtime: invisible to the parser.
        state_d = state_q;
      end else if (byte_in >= 8'hF0) begin
        // System common / SysEx: cancels running status, payload is dropped.
        status_d = 8'd0;
        state_d  = ST_IDLE;
      end else if (byte_in[7]) begin
        status_d = byte_in;
        state_d  = ST_D1;
      end else begin
        case (state_q)
          ST_IDLE: err_d = 1'b1;
          ST_D1: begin
            d1_d = byte_in[6:0];
            if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) begin
              msg_done = 1'b1;
              msg_d1   = byte_in[6:0];
            end else begin
              state_d = ST_D2;
            end
          end
          ST_D2: begin
            msg_done = 1'b1;
            msg_d1   = d1_q;
            msg_d2   = byte_in[6:0];
            state_d  = ST_D1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign match    = OMNI || (status_q[3:0] == CHANNEL);
  assign note_on  = msg_done && match && (status_q[7:4] == 4'h9) && (msg_d2 != 7'd0);
  assign note_off = msg_done && match &&
                    ((status_q[7:4] == 4'h8) || ((status_q[7:4] == 4'h9) && (msg_d2 == 7'd0)));
  assign all_off  = msg_done && match && (status_q[7:4] == 4'hB) && (msg_d1 == 7'h7B);

  // Stack update: locate the key, close the gap it leaves, then push on note-on.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (3'(i) < depth_q) && (key_q[i] == msg_d1)) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ext_key[i] = key_q[i];
      ext_vel[i] = vel_q[i];
    end
    ext_key[4] = 7'd0;
    ext_vel[4] = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (found && (2'(i) >= idx)) begin
        rem_key[i] = ext_key[i+1];
        rem_vel[i] = ext_vel[i+1];
      end else begin
        rem_key[i] = ext_key[i];
        rem_vel[i] = ext_vel[i];
      end
    end
    rem_depth = depth_q - {2'b00, found};

    for (int i = 0; i < 4; i++) begin
      key_d[i] = key_q[i];
      vel_d[i] = vel_q[i];
    end
    depth_d = depth_q;

    if (all_off) begin
      for (int i = 0; i < 4; i++) begin
        key_d[i] = 7'd0;
        vel_d[i] = 7'd0;
      end
      depth_d = 3'd0;
    end else if (note_on) begin
      // A full stack drops its bottom entry because rem[3] is never copied.
      key_d[0] = msg_d1;
      vel_d[0] = msg_d2;
      for (int i = 1; i < 4; i++) begin
        key_d[i] = rem_key[i-1];
        vel_d[i] = rem_vel[i-1];
      end
      depth_d = (rem_depth == 3'd4) ? 3'd4 : rem_depth + 3'd1;
    end else if (note_off) begin
      for (int i = 0; i < 4; i++) begin
        key_d[i] = rem_key[i];
        vel_d[i] = rem_vel[i];
      end
      depth_d = rem_depth;
    end
  end

  // Held-key stack registers.
  always_ff @(posedge clk500kHz or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i] <= 7'd0;
        vel_q[i] <= 7'd0;
      end
      depth_q <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        key_q[i] <= key_d[i];
        vel_q[i] <= vel_d[i];
      end
      depth_q <= depth_d;
    end
  end

  // Event and error outputs; pulses last one cycle, event fields hold.
  always_ff @(posedge clk500kHz or posedge RESET) begin
    if (RESET) begin
      evt_valid_q <= 1'b0;
      evt_on_q    <= 1'b0;
      evt_key_q   <= 7'd0;
      evt_vel_q   <= 7'd0;
      err_q       <= 1'b0;
    end else begin
      evt_valid_q <= note_on | note_off;
      err_q       <= err_d;
      if (note_on | note_off) begin
        evt_on_q  <= note_on;
        evt_key_q <= msg_d1;
        evt_vel_q <= note_on ? msg_d2 : 7'd0;
      end
    end
  end

  assign bus.EVT_VALID = evt_valid_q;
  assign bus.EVT_ON    = evt_on_q;
  assign bus.EVT_KEY   = evt_key_q;
  assign bus.EVT_VEL   = evt_vel_q;
  assign bus.ERR       = err_q;
  assign bus.HELD_CNT  = depth_q;
  assign bus.GATE      = (depth_q != 3'd0);
  assign bus.CUR_KEY   = (depth_q != 3'd0) ? key_q[0] : 7'd0;
  assign bus.CUR_VEL   = (depth_q != 3'd0) ? vel_q[0] : 7'd0;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed bench for midi_note_tracker: stimulus pushes expected events/errors
// into a queue, a negedge monitor pops and compares whenever the DUT pulses.
module tb_midi_note_tracker;

  localparam int W = 34;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  midi_note_tracker_if bus();

  midi_note_tracker #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk500kHz (clk),
    .RESET     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected record: {is_event, on, key, vel, gate, cur_key, cur_vel, held}
  function automatic logic [W-1:0] ev(input logic on, input logic [6:0] key, input logic [6:0] vel,
                                      input logic gate, input logic [6:0] ck, input logic [6:0] cv,
                                      input logic [2:0] held);
    return {1'b1, on, key, vel, gate, ck, cv, held};
  endfunction

  function automatic logic [W-1:0] er();
    return {W{1'b0}};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (!rst && (bus.EVT_VALID || bus.ERR)) begin
      if (bus.EVT_VALID)
        act = {1'b1, bus.EVT_ON, bus.EVT_KEY, bus.EVT_VEL, bus.GATE, bus.CUR_KEY, bus.CUR_VEL, bus.HELD_CNT};
      else
        act = {W{1'b0}};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h expected nothing", act);
      end else begin
        exp = exp_q.pop_front();
        chk("event", act, exp);
      end
    end
  end

  // Driver tasks: called at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap = 3);
    bus.MIDI_BYTE = b;
    bus.MIDI_RDY  = 1'b1;
    @(posedge clk); #1;
    bus.MIDI_RDY  = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  initial begin
    rst           = 1'b1;
    bus.MIDI_RDY  = 1'b0;
    bus.MIDI_BYTE = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_evt_valid", W'(bus.EVT_VALID), W'(0));
    chk("rst_gate",      W'(bus.GATE),      W'(0));
    chk("rst_cur_key",   W'(bus.CUR_KEY),   W'(0));
    chk("rst_held",      W'(bus.HELD_CNT),  W'(0));
    chk("rst_err",       W'(bus.ERR),       W'(0));
    chk("rst_state",     W'(dbg_state),     W'(0));

    // Note pair
    exp_q.push_back(ev(1'b1, 7'h3C, 7'h64, 1'b1, 7'h3C, 7'h64, 3'd1));
    send3(8'h90, 8'h3C, 8'h64);
    exp_q.push_back(ev(1'b0, 7'h3C, 7'h00, 1'b0, 7'h00, 7'h00, 3'd0));
    send3(8'h80, 8'h3C, 8'h00);

    // Running status
    exp_q.push_back(ev(1'b1, 7'h40, 7'h50, 1'b1, 7'h40, 7'h50, 3'd1));
    send3(8'h90, 8'h40, 8'h50);
    exp_q.push_back(ev(1'b1, 7'h43, 7'h50, 1'b1, 7'h43, 7'h50, 3'd2));
    send_byte(8'h43); send_byte(8'h50);
    exp_q.push_back(ev(1'b0, 7'h40, 7'h00, 1'b1, 7'h43, 7'h50, 3'd1));
    send_byte(8'h40); send_byte(8'h00);
    chk("rs_cur_key", W'(bus.CUR_KEY),  W'(7'h43));
    chk("rs_held",    W'(bus.HELD_CNT), W'(1));
    send3(8'hB0, 8'h7B, 8'h00);
    chk("rs_clear_held", W'(bus.HELD_CNT), W'(0));

    // Realtime interleaving, then SysEx clears running status
    exp_q.push_back(ev(1'b1, 7'h3C, 7'h64, 1'b1, 7'h3C, 7'h64, 3'd1));
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h64);
    exp_q.push_back(er());
    exp_q.push_back(er());
    send3(8'hF0, 8'h3C, 8'h64);
    chk("sys_held", W'(bus.HELD_CNT), W'(1));
    chk("sys_state", W'(dbg_state), W'(0));
    send3(8'hB0, 8'h7B, 8'h00);

    // Overflow and last-note priority
    send_byte(8'h90);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(ev(1'b1, 7'(k), 7'(k * 16), 1'b1, 7'(k), 7'(k * 16), 3'((k > 4) ? 4 : k)));
      send_byte(8'(k)); send_byte(8'(k * 16));
    end
    chk("ovf_held", W'(bus.HELD_CNT), W'(4));
    chk("ovf_cur",  W'(bus.CUR_KEY),  W'(5));
    exp_q.push_back(ev(1'b0, 7'h05, 7'h00, 1'b1, 7'h04, 7'h40, 3'd3));
    send3(8'h80, 8'h05, 8'h00);
    exp_q.push_back(ev(1'b0, 7'h01, 7'h00, 1'b1, 7'h04, 7'h40, 3'd3));
    send_byte(8'h01); send_byte(8'h40);
    // Retrigger of a held key moves it to the top
    exp_q.push_back(ev(1'b1, 7'h02, 7'h22, 1'b1, 7'h02, 7'h22, 3'd3));
    send3(8'h90, 8'h02, 8'h22);
    exp_q.push_back(ev(1'b0, 7'h04, 7'h00, 1'b1, 7'h02, 7'h22, 3'd2));
    send_byte(8'h04); send_byte(8'h00);

    // Channel filter, program change, all-notes-off
    send3(8'h91, 8'h3C, 8'h64);
    send3(8'hC0, 8'h05, 8'h06);
    exp_q.push_back(ev(1'b1, 7'h07, 7'h11, 1'b1, 7'h07, 7'h11, 3'd3));
    send3(8'h90, 8'h07, 8'h11);
    send3(8'hB1, 8'h7B, 8'h00);
    chk("ch_other_aof_held", W'(bus.HELD_CNT), W'(3));
    send3(8'hB0, 8'h7B, 8'h00);
    chk("aof_held", W'(bus.HELD_CNT), W'(0));
    chk("aof_gate", W'(bus.GATE),     W'(0));
    chk("aof_cur",  W'(bus.CUR_KEY),  W'(0));

    // Fast strobes, 2 cycles apart
    exp_q.push_back(ev(1'b1, 7'h30, 7'h01, 1'b1, 7'h30, 7'h01, 3'd1));
    send_byte(8'h90, 1); send_byte(8'h30, 1); send_byte(8'h01, 1);
    exp_q.push_back(ev(1'b0, 7'h30, 7'h00, 1'b0, 7'h00, 7'h00, 3'd0));
    send_byte(8'h30, 1); send_byte(8'h00, 3);

    // Reset mid-message discards the partial message
    send_byte(8'h90); send_byte(8'h3C);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_state", W'(dbg_state), W'(0));
    exp_q.push_back(er());
    send_byte(8'h64);

    // Strobe already high at reset release is ignored
    bus.MIDI_BYTE = 8'h3C;
    bus.MIDI_RDY  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.MIDI_RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Strobe held 5 cycles consumes one byte
    exp_q.push_back(er());
    bus.MIDI_BYTE = 8'h3C;
    bus.MIDI_RDY  = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.MIDI_RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Drain, bounded
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_note_tracker.md
# midi_note_tracker

Channel-voice message controller for the MIDI input path. It consumes the byte stream produced by the serial-to-parallel MIDI receiver (one `MIDI_BYTE` per `MIDI_RDY` pulse) and applies running status, realtime/system filtering and channel selection. It emits note-on/off events and maintains a 4-deep last-note-priority stack of held keys that drives the game's tone/sprite logic.

## Interface
- `CHANNEL`, default 4'd0: MIDI channel (0–15) whose messages are accepted.
- `OMNI`, default 1'b0: 1 = accept all channels; `CHANNEL` is ignored.

- `clk500kHz` in 1: system clock, same domain as the receiver.
- `RESET` in 1: asynchronous, active-high reset.
- `MIDI_RDY` in 1: byte strobe from the receiver.
- `MIDI_BYTE` in 8: received byte, valid while `MIDI_RDY`=1.
- `EVT_VALID` out 1: one-cycle pulse per note event.
- `EVT_ON` out 1: 1 = note-on, 0 = note-off.
- `EVT_KEY` out 7: key number of the event.
- `EVT_VEL` out 7: velocity of the event (0 for note-off).
- `GATE` out 1: 1 while at least one key is held.
- `CUR_KEY` out 7: top-of-stack key; 0 when empty.
- `CUR_VEL` out 7: velocity of the top-of-stack key; 0 when empty.
- `HELD_CNT` out 3: stack depth, 0–4.
- `ERR` out 1: one-cycle pulse when a data byte arrives with no running status.

## Operation
- Byte acceptance:
  - A byte is consumed on the clock edge where `MIDI_RDY`=1 and its registered previous value is 0.
  - A strobe held high counts once.
  - The previous-value register resets to 1, so a strobe that is already high at reset release is ignored.
- Byte classes:
  - Realtime 0xF8–0xFF: ignored entirely. No change to state, running status or outputs.
  - System 0xF0–0xF7: clears running status and goes to IDLE. SysEx payload is therefore dropped.
  - Status 0x80–0xEF: stored as running status. Go to D1.
  - Data 0x00–0x7F: handled per state.
- Parser FSM, states IDLE, D1, D2:
  - IDLE + data byte: byte is dropped and `ERR` pulses.
  - D1 + data: byte latched as d1. For status 0xCn/0xDn the message is complete and the FSM stays in D1. Otherwise go to D2.
  - D2 + data: byte latched as d2. The message completes and the FSM returns to D1 (running status).
  - A status byte is accepted in any state and aborts any partial message.
- Message completion actions. "Match" means `OMNI`=1 or n==`CHANNEL`.
  - 0x9n, match, d2≠0: note-on(d1, d2).
  - 0x9n, match, d2=0: note-off(d1).
  - 0x8n, match: note-off(d1); d2 is discarded.
  - 0xBn, match, d1=0x7B: all-notes-off. Stack is cleared and no `EVT_VALID`.
  - All other messages, including non-matching channels: consumed silently.
- Stack, 4 entries of {key, vel}; entry 0 is the top:
  - note-on, key present: the entry is removed and re-pushed on top with the new velocity.
  - note-on, key absent, depth<4: pushed on top and depth increments.
  - note-on, key absent, depth=4: the bottom entry is discarded, then the key is pushed. Depth stays 4.
  - note-off, key present: the entry is removed, entries below shift up, and depth decrements.
  - note-off, key absent: no stack change. `EVT_VALID` still pulses.
- Derived outputs: `GATE` = (`HELD_CNT`≠0). `CUR_KEY`/`CUR_VEL` = entry 0, or 0 when empty.

## Timing
- Reset: all outputs 0; FSM IDLE; running status cleared; stack empty. Reset mid-message discards the partial message.
- Latency: `EVT_*`, `ERR`, stack and derived outputs are registered on the accepting edge, so they are visible 1 cycle after the completing byte's first `MIDI_RDY`-high cycle.
- `EVT_VALID` and `ERR` are high for exactly 1 cycle. `EVT_KEY`/`EVT_VEL`/`EVT_ON` hold their values until the next event.
- `GATE`, `CUR_*` and `HELD_CNT` change in the same cycle that `EVT_VALID` rises.
- Minimum byte spacing at the receiver is about 160 cycles. Correct operation is still required for strobes 2 cycles apart.

## Test plan
- Note pair: bytes 0x90,0x3C,0x64 then 0x80,0x3C,0x00.
  - First message: `EVT_VALID` pulses with ON=1, KEY=0x3C, VEL=0x64; `GATE`=1.
  - Second message: pulse with ON=0, KEY=0x3C, VEL=0; `GATE`=0, `HELD_CNT`=0.
- Running status: 0x90,0x40,0x50,0x43,0x50,0x40,0x00.
  - Three events: on 0x40, on 0x43, off 0x40.
  - Final state: `CUR_KEY`=0x43, `HELD_CNT`=1.
- Realtime interleaving: 0x90,0xF8,0x3C,0xFE,0x64 gives a single note-on 0x3C/0x64. Then 0xF0,0x3C,0x64 gives no event and `ERR` pulses twice.
- Overflow/priority: note-on for keys 1,2,3,4,5 gives `HELD_CNT`=4 and `CUR_KEY`=5. Note-off 5 gives `CUR_KEY`=4. Note-off 1 (already evicted) gives no stack change, but `EVT_VALID` still pulses.
- Channel filter (`CHANNEL`=0, `OMNI`=0): 0x91,0x3C,0x64 gives no event. 0xB0,0x7B,0x00 with 3 keys held gives `HELD_CNT`=0 and no `EVT_VALID`.
- Reset and strobe: `RESET` asserted after 0x90,0x3C. Then 0x64 gives `ERR` and no event. `MIDI_RDY` held high for 5 cycles consumes only one byte.
